softmax_arbiter: RTL and testbench
==================================

// Module: softmax_arbiter
// PURPOSE
//  Shares one softmax_approx engine between NUM_REQ requesters, e.g. per-head attention score producers.
//  Round-robin grants, engine start pulse, completion routing and a timeout watchdog.
//  The data path is external: eng_sel drives the A_in mux, and A_out is broadcast to all requesters.
//  Each requester consumes A_out on its own req_done pulse.
// PARAMETERS
//  NUM_REQ   4     number of requesters (>=2)
//  TIMEOUT   1024  max cycles in S_WAIT before abort; 0 disables the watchdog
//  CNT_W     16    width of job_cnt
// PORTS
//  clk           in   1                  clock, all logic on posedge
//  rst_n         in   1                  asynchronous active-low reset
//  req           in   NUM_REQ            level request per requester, held until its req_done/req_err
//  gnt           out  NUM_REQ            one-hot grant, high from S_ISSUE through S_RELEASE
//  req_done      out  NUM_REQ            one-cycle pulse to granted requester: engine result valid on A_out
//  req_err       out  NUM_REQ            one-cycle pulse to granted requester: job aborted by timeout
//  eng_sel       out  $clog2(NUM_REQ)    index of granted requester (input mux select)
//  eng_start     out  1                  one-cycle start pulse to softmax_approx
//  eng_done      in   1                  softmax_approx done
//  busy          out  1                  high whenever state != S_IDLE
//  timeout_flag  out  1                  sticky; set on any timeout, cleared only by reset
//  job_cnt       out  CNT_W              count of successful jobs, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): state=S_IDLE, all outputs 0, rr_ptr=0, wd_cnt=0. Applies mid-job too.
//   Any eng_done arriving after reset deasserts is ignored unless state is S_WAIT.
//  All outputs are registered.
//  FSM:
//   S_IDLE: if |req, pick first set bit scanning rr_ptr, rr_ptr+1, ... NUM_REQ-1, wrapping to 0.
//    Latch winner into eng_sel and gnt; go to S_ISSUE.
//   S_ISSUE: eng_start=1 for exactly this cycle; wd_cnt cleared; go to S_WAIT.
//   S_WAIT: eng_start=0. eng_done=1 -> go to S_RELEASE (ok).
//    Else if TIMEOUT!=0 and wd_cnt==TIMEOUT-1 -> go to S_RELEASE (err). Else wd_cnt++.
//   S_RELEASE: on ok, pulse req_done[eng_sel] and increment job_cnt. On err, pulse req_err[eng_sel]
//    and set timeout_flag. In both cases rr_ptr = (eng_sel+1) mod NUM_REQ; go to S_IDLE, clearing gnt.
//  Latency: req rises in S_IDLE at cycle t -> gnt at t+1, eng_start at t+1.
//   eng_done sampled at cycle d -> req_done at d+1; next arbitration can grant at d+3.
//  eng_done outside S_WAIT is ignored; it never completes a job. That includes eng_done in S_ISSUE.
//  eng_done and the timeout condition in the same cycle: eng_done wins (ok, no error).
//  A requester dropping req mid-job does not abort: the job completes and req_done still pulses.
//  A requester still holding req after its req_done is rearbitrated in S_IDLE. It has lowest priority that round.
//  Only one of gnt/req_done/req_err bits is ever set; req_done and req_err are never high together.
//  job_cnt wraps from 2^CNT_W-1 to 0 silently.
//  Fairness: with all requests held high, grants cycle 0,1,..,NUM_REQ-1,0,...
// TESTING
//  T1 single: req=4'b0100, eng_done 20 cycles after eng_start.
//   -> gnt=0100, eng_sel=2, one eng_start pulse, req_done=0100 one cycle after eng_done, job_cnt=1.
//  T2 round-robin: req=4'b1111 held, engine done after 5 cycles.
//   -> grant order 0,1,2,3,0. No idle gap beyond 2 cycles between jobs; job_cnt=5 after 5 jobs.
//  T3 timeout: TIMEOUT=16, req=4'b0001, eng_done never asserts.
//   -> req_err[0] 17 cycles after eng_start, timeout_flag=1, job_cnt=0.
//   Then req=4'b0010 with normal done -> req_done[1], timeout_flag stays 1.
//  T4 stray/simultaneous: eng_done pulsed while S_IDLE -> no req_done, job_cnt unchanged.
//   eng_done on the same cycle wd_cnt hits TIMEOUT-1 -> req_done, no req_err.
//  T5 reset mid-job: rst_n low during S_WAIT for requester 3.
//   -> all outputs 0 immediately (async), rr_ptr=0. After release with req=4'b1001 -> first grant is 0.
//  T6 withdraw: req[1] dropped during S_WAIT -> req_done[1] still pulses, then requester 1 is not regranted.

Source files
------------

// File: rtl/softmax_arbiter.sv
// rtl/softmax_arbiter.sv - round-robin arbiter sharing one softmax_approx engine across requesters
module softmax_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [NUM_REQ-1:0]         req_err,
  output logic [$clog2(NUM_REQ)-1:0] eng_sel,
  output logic                       eng_start,
  input  logic                       eng_done,
  output logic                       busy,
  output logic                       timeout_flag,
  output logic [CNT_W-1:0]           job_cnt
);

  localparam int SEL_W = $clog2(NUM_REQ);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   req_done_q, req_done_d;
  logic [NUM_REQ-1:0]   req_err_q, req_err_d;
  logic [SEL_W-1:0]     eng_sel_q, eng_sel_d;
  logic                 eng_start_q, eng_start_d;
  logic                 busy_q, busy_d;
  logic                 timeout_flag_q, timeout_flag_d;
  logic [CNT_W-1:0]     job_cnt_q, job_cnt_d;
  logic [SEL_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;

  logic                 win_found;
  logic [SEL_W-1:0]     win_idx;
  logic [SEL_W-1:0]     sel_next;

  // Round-robin pick: first requester at or after rr_ptr, wrapping around
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req[SEL_W'((int'(rr_ptr_q) + k) % NUM_REQ)]) begin
        win_found = 1'b1;
        win_idx   = SEL_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign sel_next = (eng_sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : eng_sel_q + SEL_W'(1);

  // Next-state and next-output logic; outputs are computed for the state being entered so they come straight off flops
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    eng_sel_d      = eng_sel_q;
    eng_start_d    = 1'b0;
    req_done_d     = '0;
    req_err_d      = '0;
    rr_ptr_d       = rr_ptr_q;
    wd_cnt_d       = wd_cnt_q;
    job_cnt_d      = job_cnt_q;
    timeout_flag_d = timeout_flag_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d     = S_ISSUE;
          gnt_d       = NUM_REQ'(1) << win_idx;
          eng_sel_d   = win_idx;
          eng_start_d = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d  = S_WAIT;
        wd_cnt_d = '0;
      end
      S_WAIT: begin
        // a completion in the same cycle as the watchdog limit counts as success
        if (eng_done) begin
          state_d    = S_RELEASE;
          req_done_d = gnt_q;
          job_cnt_d  = job_cnt_q + CNT_W'(1);
          rr_ptr_d   = sel_next;
        end else if ((TIMEOUT != 0) && (wd_cnt_q == WD_LAST)) begin
          state_d        = S_RELEASE;
          req_err_d      = gnt_q;
          timeout_flag_d = 1'b1;
          rr_ptr_d       = sel_next;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and registered outputs; reset also aborts any job in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      gnt_q          <= '0;
      req_done_q     <= '0;
      req_err_q      <= '0;
      eng_sel_q      <= '0;
      eng_start_q    <= 1'b0;
      busy_q         <= 1'b0;
      timeout_flag_q <= 1'b0;
      job_cnt_q      <= '0;
      rr_ptr_q       <= '0;
      wd_cnt_q       <= '0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      req_done_q     <= req_done_d;
      req_err_q      <= req_err_d;
      eng_sel_q      <= eng_sel_d;
      eng_start_q    <= eng_start_d;
      busy_q         <= busy_d;
      timeout_flag_q <= timeout_flag_d;
      job_cnt_q      <= job_cnt_d;
      rr_ptr_q       <= rr_ptr_d;
      wd_cnt_q       <= wd_cnt_d;
    end
  end

  assign gnt          = gnt_q;
  assign req_done     = req_done_q;
  assign req_err      = req_err_q;
  assign eng_sel      = eng_sel_q;
  assign eng_start    = eng_start_q;
  assign busy         = busy_q;
  assign timeout_flag = timeout_flag_q;
  assign job_cnt      = job_cnt_q;

endmodule

// File: tb/tb_softmax_arbiter.sv
// tb/tb_softmax_arbiter.sv - scoreboard bench for softmax_arbiter
module tb_softmax_arbiter;

  typedef struct packed {
    logic [3:0]  done;
    logic [3:0]  err;
    logic [15:0] cnt;
    logic        tf;
  } exp_t;

  logic        clk = 1'b0;
  logic [1:0]  rst_n_v;
  logic [1:0]  eng_done_v;
  logic [3:0]  req_a        [2];
  logic [3:0]  gnt_a        [2];
  logic [3:0]  req_done_a   [2];
  logic [3:0]  req_err_a    [2];
  logic [1:0]  eng_sel_a    [2];
  logic        eng_start_a  [2];
  logic        busy_a       [2];
  logic        tflag_a      [2];
  logic [15:0] job_cnt_a    [2];

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] exp_cnt [2];
  logic        exp_tf  [2];
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  softmax_arbiter #(.NUM_REQ(4), .TIMEOUT(1024), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n_v[0]), .req(req_a[0]), .gnt(gnt_a[0]),
    .req_done(req_done_a[0]), .req_err(req_err_a[0]), .eng_sel(eng_sel_a[0]),
    .eng_start(eng_start_a[0]), .eng_done(eng_done_v[0]), .busy(busy_a[0]),
    .timeout_flag(tflag_a[0]), .job_cnt(job_cnt_a[0])
  );

  softmax_arbiter #(.NUM_REQ(4), .TIMEOUT(16), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n_v[1]), .req(req_a[1]), .gnt(gnt_a[1]),
    .req_done(req_done_a[1]), .req_err(req_err_a[1]), .eng_sel(eng_sel_a[1]),
    .eng_start(eng_start_a[1]), .eng_done(eng_done_v[1]), .busy(busy_a[1]),
    .timeout_flag(tflag_a[1]), .job_cnt(job_cnt_a[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse pops the oldest expectation for that instance
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if ((req_done_a[i] | req_err_a[i]) != 4'b0) begin
        exp_t e;
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
          chk($sformatf("unexpected_resp%0d", i), {req_done_a[i], req_err_a[i]}, 32'h0);
        end else begin
          if (i == 0) e = q0.pop_front();
          else        e = q1.pop_front();
          chk($sformatf("resp_done%0d", i), req_done_a[i], e.done);
          chk($sformatf("resp_err%0d", i), req_err_a[i], e.err);
          chk($sformatf("resp_job_cnt%0d", i), job_cnt_a[i], e.cnt);
          chk($sformatf("resp_tflag%0d", i), tflag_a[i], e.tf);
        end
      end
    end
  end

  // One job: push expectation, wait for start, then complete after delay or let it time out (TIMEOUT=16)
  task automatic serve(input int i, input logic [1:0] sel, input int delay, input bit to_err, input bit drop);
    exp_t e;
    logic [3:0] g;
    int n;
    g = 4'b0001 << sel;
    if (to_err) exp_tf[i] = 1'b1;
    else        exp_cnt[i] = exp_cnt[i] + 16'd1;
    e.done = to_err ? 4'b0 : g;
    e.err  = to_err ? g : 4'b0;
    e.cnt  = exp_cnt[i];
    e.tf   = exp_tf[i];
    if (i == 0) q0.push_back(e);
    else        q1.push_back(e);
    n = 0;
    while (!eng_start_a[i] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", eng_start_a[i], 1);
    chk("gnt", gnt_a[i], g);
    chk("eng_sel", eng_sel_a[i], sel);
    @(negedge clk);
    chk("start_pulse", eng_start_a[i], 0);
    if (drop) req_a[i] = 4'b0;
    if (to_err) begin
      repeat (16) @(negedge clk);
    end else begin
      repeat (delay - 1) @(negedge clk);
      eng_done_v[i] = 1'b1;
      @(negedge clk);
      eng_done_v[i] = 1'b0;
    end
    chk("resp_timing", req_done_a[i] | req_err_a[i], g);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    rst_n_v    = 2'b00;
    eng_done_v = 2'b00;
    req_a[0]   = 4'b0;
    req_a[1]   = 4'b0;
    exp_cnt[0] = 16'd0;
    exp_cnt[1] = 16'd0;
    exp_tf[0]  = 1'b0;
    exp_tf[1]  = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_gnt", {gnt_a[i], req_done_a[i], req_err_a[i]}, 0);
      chk("rst_misc", {eng_sel_a[i], eng_start_a[i], busy_a[i], tflag_a[i]}, 0);
      chk("rst_job_cnt", job_cnt_a[i], 0);
    end
    rst_n_v = 2'b11;
    @(negedge clk);

    // T2 round robin with all requests held
    req_a[0] = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      serve(0, 2'(j % 4), 5, 1'b0, 1'b0);
      if (j == 4) begin
        req_a[0] = 4'b0;
      end else begin
        @(negedge clk);
        chk("rr_gap_idle", eng_start_a[0], 0);
        @(negedge clk);
        chk("rr_gap_start", eng_start_a[0], 1);
      end
    end
    chk("t2_job_cnt", job_cnt_a[0], 5);

    // T1 single requester, done 20 cycles after start
    repeat (2) @(negedge clk);
    req_a[0] = 4'b0100;
    @(negedge clk);
    chk("t1_gnt_latency", gnt_a[0], 4'b0100);
    chk("t1_start_latency", eng_start_a[0], 1);
    serve(0, 2'd2, 20, 1'b0, 1'b0);
    req_a[0] = 4'b0;

    // T3 timeout then a normal job, flag sticks
    req_a[1] = 4'b0001;
    serve(1, 2'd0, 0, 1'b1, 1'b0);
    req_a[1] = 4'b0;
    chk("t3_tflag", tflag_a[1], 1);
    chk("t3_job_cnt", job_cnt_a[1], 0);
    repeat (2) @(negedge clk);
    req_a[1] = 4'b0010;
    serve(1, 2'd1, 5, 1'b0, 1'b0);
    req_a[1] = 4'b0;

    // T4 stray eng_done while idle, then done coinciding with the watchdog limit
    repeat (3) @(negedge clk);
    eng_done_v[1] = 1'b1;
    @(negedge clk);
    eng_done_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_stray_busy", busy_a[1], 0);
    chk("t4_stray_job_cnt", job_cnt_a[1], 1);
    req_a[1] = 4'b0100;
    serve(1, 2'd2, 16, 1'b0, 1'b0);
    req_a[1] = 4'b0;
    chk("t4_tflag_kept", tflag_a[1], 1);

    // T5 asynchronous reset in the middle of a job for requester 3
    repeat (2) @(negedge clk);
    req_a[0] = 4'b1000;
    n = 0;
    while (!eng_start_a[0] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_start_seen", eng_start_a[0], 1);
    chk("t5_gnt", gnt_a[0], 4'b1000);
    repeat (5) @(negedge clk);
    rst_n_v[0] = 1'b0;
    #1;
    chk("t5_async_gnt", gnt_a[0], 0);
    chk("t5_async_busy", busy_a[0], 0);
    chk("t5_async_job_cnt", job_cnt_a[0], 0);
    chk("t5_async_sel", eng_sel_a[0], 0);
    exp_cnt[0] = 16'd0;
    @(negedge clk);
    req_a[0]   = 4'b1001;
    rst_n_v[0] = 1'b1;
    serve(0, 2'd0, 5, 1'b0, 1'b0);
    req_a[0] = 4'b1000;
    serve(0, 2'd3, 5, 1'b0, 1'b0);
    req_a[0] = 4'b0;

    // T6 requester 1 withdraws during the wait; job still completes
    repeat (2) @(negedge clk);
    req_a[0] = 4'b0010;
    serve(0, 2'd1, 8, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_not_regranted", {busy_a[0], gnt_a[0]}, 0);

    repeat (5) @(negedge clk);
    chk("queues_empty", q0.size() + q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
